textcon_ctrl: RTL and testbench
===============================

// Module: textcon_ctrl
// PURPOSE
//  Console controller that sequences character writes into the 32x28 overlay text buffer.
//  - Consumes a byte stream (valid/ready) from the iosys CPU or debug UART.
//  - Interprets control codes and tracks the cursor.
//  - Emits one-cycle write commands in the text display's register format (cmd/x/y/char).
//  - Sits between the byte producer and the text display's reg_char_we/reg_char_di inputs.
// PARAMETERS
//  COLS   32     columns per row; cursor x range 0..COLS-1
//  ROWS   28     rows per screen; cursor y range 0..ROWS-1
//  BLANK  8'h20  character written by the clear, backspace and tab sweeps
// PORTS
//  clk          in   1   main logic clock (same clock as the display's write port)
//  resetn       in   1   asynchronous active-low reset
//  s_valid      in   1   input byte valid
//  s_ready      out  1   controller can accept a byte
//  s_data       in   8   input byte
//  busy         out  1   high whenever the state is not IDLE
//  cur_x        out  5   cursor column
//  cur_y        out  5   cursor row
//  reg_char_we  out  4   write strobe to the text display; 4'b0001 on a write cycle, else 0
//  reg_char_di  out  32  {8'h00, 3'b0, x[4:0], 3'b0, y[4:0], char[7:0]}
// BEHAVIOUR
//  Reset values:
//  - s_ready=0, busy=1, cur_x=0, cur_y=0, reg_char_we=0, reg_char_di=0, state=CLRSCR.
//  - The sweep counter is zeroed.
//  - Reset asserted mid-operation aborts immediately; the screen clear restarts after release.
//  States:
//  - IDLE: s_ready=1. A byte is accepted when s_valid && s_ready.
//  - PUT: one write at the cursor, then cursor advance.
//  - CLRLINE: COLS writes of BLANK to row cur_y, x ascending 0..COLS-1, one per cycle.
//  - CLRSCR: ROWS*COLS writes, row-major from (0,0) to (COLS-1,ROWS-1); afterwards cursor=(0,0).
//  - TAB: only when TEXTCON_TAB_EN is defined; see CONFIGURATION.
//  Decode at accept, cycle N:
//  - 0x20..0x7E and 0x80..0xFF go to PUT.
//    - Write at (cur_x,cur_y) is on the outputs at N+1.
//    - s_ready is low at N+1 and returns high at N+2 (1 char per 2 cycles).
//  - 0x0A LF: cur_x=0, cur_y=(cur_y==ROWS-1)?0:cur_y+1, then CLRLINE of the new row.
//  - 0x0D CR: cur_x=0. No write; back in IDLE at N+1.
//  - 0x08 BS:
//    - cur_x>0: cur_x-1, then PUT of BLANK at the new x with no advance.
//    - cur_x==0: no effect.
//  - 0x0C FF: CLRSCR.
//  - Any other byte <0x20: consumed, no write, no cursor move.
//  Advance after PUT:
//  - cur_x<COLS-1: cur_x+1, then IDLE.
//  - cur_x==COLS-1: implicit LF, i.e. wrap to next row (row ROWS-1 wraps to 0), then CLRLINE.
//  Timing and ordering:
//  - At most one write per cycle; writes are never dropped or merged.
//  - cur_x/cur_y update on the cycle the state leaves PUT (or on accept for CR/LF/BS).
//  - busy and !s_ready are asserted on the same cycles.
//  - s_valid without s_ready: the byte stays pending; s_data is not sampled.
//  - Bytes >=0x80 are written unchanged; the display renders them as '?'.
// CONFIGURATION
//  TEXTCON_TAB_EN defined:
//  - 0x09 enters TAB and writes BLANK at cur_x, advancing, until cur_x%4==0 or the row ends.
//  - Each write takes 1 cycle.
//  - Leaving column COLS-1 performs the implicit LF and CLRLINE.
//  - A tab at cur_x%4==0 writes 4 blanks.
//  TEXTCON_TAB_EN undefined:
//  - 0x09 is treated as any other ignored control code.
//  - The TAB state and its logic are not built.
// STRUCTURE
//  textcon_pkg: state enum, COLS/ROWS defaults, ASCII constants (LF, CR, BS, FF, TAB, BLANK).
//  Sub-module textcon_sweep:
//  - x/y sweep counter with start_line, start_screen and done.
//  - Shared by CLRLINE and CLRSCR.
//  Cursor logic and FSM are inline in textcon_ctrl.
// TESTING
//  1. Release reset:
//     - 896 consecutive writes, first x=0,y=0, last x=31,y=27, all char 8'h20.
//     - s_ready rises the cycle after the last write.
//  2. Stream "AB" from (0,0):
//     - writes 0x41 at (0,0), then 0x42 at (1,0), each 1 cycle after its accept.
//     - ends with cur_x=2.
//  3. cur_x=31,y=27, send 0x5A:
//     - writes 0x5A at (31,27), then 32 blanks to row 0.
//     - ends with cur=(0,0).
//  4. Send 0x08 at cur_x=5:
//     - one blank written at (4,y), cur_x=4.
//     - 0x08 at cur_x=0 produces no write.
//  5. With TEXTCON_TAB_EN, 0x09 at cur_x=5:
//     - blanks at x=5,6,7, cur_x=8.
//     - without the macro: no write, cur_x stays 5.
//  6. Assert resetn low during CLRLINE:
//     - reg_char_we=0 immediately.
//     - after release a full 896-write clear restarts from (0,0).

Source files
------------

// File: rtl/textcon_pkg.sv
// Shared constants for the overlay text console controller.
// Geometry defaults, ASCII control codes, FSM state encodings, row-wrap helper.
package textcon_pkg;

  localparam int DEF_COLS = 32;
  localparam int DEF_ROWS = 28;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_TAB   = 8'h09;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_DEL   = 8'h7F;
  localparam logic [7:0] CH_BLANK = 8'h20;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PUT     = 3'd1;
  localparam logic [2:0] S_CLRLINE = 3'd2;
  localparam logic [2:0] S_CLRSCR  = 3'd3;
  localparam logic [2:0] S_TAB     = 3'd4;

  function automatic logic [4:0] next_row(
    input logic [4:0] y,
    input int         rows
  );
    return (y == 5'(rows - 1)) ? 5'd0 : y + 5'd1;
  endfunction

endpackage

// File: rtl/textcon_sweep.sv
// x/y sweep counter shared by the line clear and screen clear.
// Ports: start_line_i/row_i, start_screen_i, step_i in; x_o, y_o, done_o out.
module textcon_sweep
  import textcon_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS
) (
  input  logic       clk,
  input  logic       rst_ni,
  input  logic       start_line_i,
  input  logic       start_screen_i,
  input  logic [4:0] row_i,
  input  logic       step_i,
  output logic [4:0] x_o,
  output logic [4:0] y_o,
  output logic       done_o
);

  logic [4:0] x_q, x_d;
  logic [4:0] y_q, y_d;
  logic       line_q, line_d;

  assign x_o = x_q;
  assign y_o = y_q;
  // Line mode ends at the row's last column, screen mode at the last cell.
  assign done_o = (x_q == 5'(COLS - 1)) &&
                  (line_q || (y_q == 5'(ROWS - 1)));

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    line_d = line_q;
    if (start_screen_i) begin
      x_d    = 5'd0;
      y_d    = 5'd0;
      line_d = 1'b0;
    end else if (start_line_i) begin
      x_d    = 5'd0;
      y_d    = row_i;
      line_d = 1'b1;
    end else if (step_i) begin
      if (x_q == 5'(COLS - 1)) begin
        x_d = 5'd0;
        y_d = next_row(y_q, ROWS);
      end else begin
        x_d = x_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q    <= 5'd0;
      y_q    <= 5'd0;
      line_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      line_q <= line_d;
    end
  end

endmodule

// File: rtl/textcon_ctrl.sv
// Console controller: byte stream in, one-cycle text display writes out.
// Ports: s_valid/s_ready/s_data in, busy, cur_x/cur_y, reg_char_we/di out. Tab: TEXTCON_TAB_EN.
module textcon_ctrl
  import textcon_pkg::*;
#(
  parameter int         COLS  = DEF_COLS,
  parameter int         ROWS  = DEF_ROWS,
  parameter logic [7:0] BLANK = CH_BLANK
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  output logic        busy,
  output logic [4:0]  cur_x,
  output logic [4:0]  cur_y,
  output logic [3:0]  reg_char_we,
  output logic [31:0] reg_char_di
);

  logic [2:0] state_q, state_d;
  logic [4:0] cx_q, cx_d;
  logic [4:0] cy_q, cy_d;
  logic [7:0] ch_q, ch_d;
  logic       noadv_q, noadv_d;
  // Low only until the first edge after reset, keeping writes off in reset.
  logic       go_q;

  logic       sw_line, sw_scr, sw_step, sw_done;
  logic [4:0] sw_x, sw_y;

  logic       wr;
  logic [4:0] wx, wy;
  logic [7:0] wc;
  logic       is_put, last_col;

  textcon_sweep #(.COLS(COLS), .ROWS(ROWS)) u_sweep (
    .clk            (clk),
    .rst_ni         (resetn),
    .start_line_i   (sw_line),
    .start_screen_i (sw_scr),
    .row_i          (cy_d),
    .step_i         (sw_step),
    .x_o            (sw_x),
    .y_o            (sw_y),
    .done_o         (sw_done)
  );

  assign is_put   = (s_data >= 8'h20) && (s_data != CH_DEL);
  assign last_col = (cx_q == 5'(COLS - 1));

  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    ch_d    = ch_q;
    noadv_d = noadv_q;
    sw_line = 1'b0;
    sw_scr  = 1'b0;
    sw_step = 1'b0;
    wr      = 1'b0;
    wx      = cx_q;
    wy      = cy_q;
    wc      = ch_q;
    if (go_q) begin
      unique case (state_q)
        S_IDLE: begin
          if (s_valid) begin
            unique case (1'b1)
              is_put: begin
                ch_d    = s_data;
                noadv_d = 1'b0;
                state_d = S_PUT;
              end
              (s_data == CH_LF): begin
                cx_d    = 5'd0;
                cy_d    = next_row(cy_q, ROWS);
                sw_line = 1'b1;
                state_d = S_CLRLINE;
              end
              (s_data == CH_CR): cx_d = 5'd0;
              (s_data == CH_BS): begin
                if (cx_q != 5'd0) begin
                  cx_d    = cx_q - 5'd1;
                  ch_d    = BLANK;
                  noadv_d = 1'b1;
                  state_d = S_PUT;
                end
              end
              (s_data == CH_FF): begin
                sw_scr  = 1'b1;
                state_d = S_CLRSCR;
              end
`ifdef TEXTCON_TAB_EN
              (s_data == CH_TAB): state_d = S_TAB;
`endif
              default: ;
            endcase
          end
        end
        S_PUT: begin
          wr = 1'b1;
          if (noadv_q) begin
            state_d = S_IDLE;
          end else if (last_col) begin
            cx_d    = 5'd0;
            cy_d    = next_row(cy_q, ROWS);
            sw_line = 1'b1;
            state_d = S_CLRLINE;
          end else begin
            cx_d    = cx_q + 5'd1;
            state_d = S_IDLE;
          end
        end
        S_CLRLINE, S_CLRSCR: begin
          wr      = 1'b1;
          wx      = sw_x;
          wy      = sw_y;
          wc      = BLANK;
          sw_step = 1'b1;
          if (sw_done) begin
            state_d = S_IDLE;
            if (state_q == S_CLRSCR) begin
              cx_d = 5'd0;
              cy_d = 5'd0;
            end
          end
        end
`ifdef TEXTCON_TAB_EN
        S_TAB: begin
          wr = 1'b1;
          wc = BLANK;
          if (last_col) begin
            cx_d    = 5'd0;
            cy_d    = next_row(cy_q, ROWS);
            sw_line = 1'b1;
            state_d = S_CLRLINE;
          end else begin
            cx_d = cx_q + 5'd1;
            // Stop once the next column is a tab stop.
            if (cx_d[1:0] == 2'b00) state_d = S_IDLE;
          end
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_CLRSCR;
      cx_q    <= 5'd0;
      cy_q    <= 5'd0;
      ch_q    <= 8'h00;
      noadv_q <= 1'b0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      ch_q    <= ch_d;
      noadv_q <= noadv_d;
      go_q    <= 1'b1;
    end
  end

  assign s_ready     = (state_q == S_IDLE);
  assign busy        = ~s_ready;
  assign cur_x       = cx_q;
  assign cur_y       = cy_q;
  assign reg_char_we = wr ? 4'b0001 : 4'b0000;
  assign reg_char_di = wr ? {8'h00, 3'b0, wx, 3'b0, wy, wc} : 32'h0;

endmodule

// File: tb/tb_textcon_ctrl.sv
// Directed bench for textcon_ctrl: table of byte commands plus
// hand sequences for reset clear, accept latency, wrap and reset abort.
module tb_textcon_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_ready, busy;
  logic [4:0]  cur_x, cur_y;
  logic [3:0]  reg_char_we;
  logic [31:0] reg_char_di;

  textcon_ctrl dut (
    .clk         (clk),
    .resetn      (resetn),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .busy        (busy),
    .cur_x       (cur_x),
    .cur_y       (cur_y),
    .reg_char_we (reg_char_we),
    .reg_char_di (reg_char_di)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] wq[$];

  always @(negedge clk) begin
    if (reg_char_we != 4'b0000) wq.push_back(reg_char_di);
  end

  typedef struct {
    logic [7:0]  d;
    int          nw;
    logic [31:0] first;
    logic [31:0] last;
    int          ex;
    int          ey;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] mk(int x, int y, logic [7:0] c);
    return {8'h00, 3'b0, 5'(x), 3'b0, 5'(y), c};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic wait_ready(string tag, output bit prev_we);
    bit ok;
    ok = 1'b0;
    prev_we = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
      prev_we = (reg_char_we != 4'b0000);
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL %s: s_ready timeout got 0 want 1", tag);
    end
  endtask

  task automatic send(string tag, logic [7:0] b);
    bit pw;
    wait_ready(tag, pw);
    #1;
    s_valid = 1'b1;
    s_data  = b;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    wait_ready(tag, pw);
  endtask

  task automatic check_clear(string tag);
    bit pw;
    int errs;
    wait_ready(tag, pw);
    chk({tag, "_count"}, wq.size(), 896);
    errs = 0;
    foreach (wq[i]) begin
      if (wq[i] !== mk(i % 32, i / 32, 8'h20)) errs++;
    end
    chk({tag, "_order"}, errs, 0);
    chk({tag, "_first"}, (wq.size() > 0) ? wq[0] : '1, mk(0, 0, 8'h20));
    chk({tag, "_last"}, (wq.size() > 0) ? wq[$] : '1, mk(31, 27, 8'h20));
    chk({tag, "_rdy_after_last"}, pw, 1);
    chk({tag, "_cur"}, {cur_x, cur_y}, 10'd0);
  endtask

  initial begin
    bit pw;
    logic [31:0] fw, lw;

    tbl.push_back('{8'h0D, 0, 0, 0, 0, 0});
    tbl.push_back('{8'h41, 1, mk(0, 0, 8'h41), mk(0, 0, 8'h41), 1, 0});
    tbl.push_back('{8'h42, 1, mk(1, 0, 8'h42), mk(1, 0, 8'h42), 2, 0});
    tbl.push_back('{8'h0D, 0, 0, 0, 0, 0});
    tbl.push_back('{8'h07, 0, 0, 0, 0, 0});
    tbl.push_back('{8'h08, 0, 0, 0, 0, 0});
    tbl.push_back('{8'h80, 1, mk(0, 0, 8'h80), mk(0, 0, 8'h80), 1, 0});
    tbl.push_back('{8'hFF, 1, mk(1, 0, 8'hFF), mk(1, 0, 8'hFF), 2, 0});
    tbl.push_back('{8'h43, 1, mk(2, 0, 8'h43), mk(2, 0, 8'h43), 3, 0});
    tbl.push_back('{8'h44, 1, mk(3, 0, 8'h44), mk(3, 0, 8'h44), 4, 0});
    tbl.push_back('{8'h45, 1, mk(4, 0, 8'h45), mk(4, 0, 8'h45), 5, 0});
    tbl.push_back('{8'h08, 1, mk(4, 0, 8'h20), mk(4, 0, 8'h20), 4, 0});
    tbl.push_back('{8'h46, 1, mk(4, 0, 8'h46), mk(4, 0, 8'h46), 5, 0});
`ifdef TEXTCON_TAB_EN
    tbl.push_back('{8'h09, 3, mk(5, 0, 8'h20), mk(7, 0, 8'h20), 8, 0});
`else
    tbl.push_back('{8'h09, 0, 0, 0, 5, 0});
`endif
    tbl.push_back('{8'h0A, 32, mk(0, 1, 8'h20), mk(31, 1, 8'h20), 0, 1});
    tbl.push_back('{8'h1B, 0, 0, 0, 0, 1});
    tbl.push_back('{8'h0C, 896, mk(0, 0, 8'h20), mk(31, 27, 8'h20), 0, 0});

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_ready", s_ready, 0);
    chk("rst_busy", busy, 1);
    chk("rst_we", reg_char_we, 0);
    chk("rst_di", reg_char_di, 0);
    chk("rst_cur", {cur_x, cur_y}, 10'd0);

    wq.delete();
    #1 resetn = 1'b1;
    check_clear("clr0");

    // Accept latency: write at N+1, ready back at N+2.
    #1;
    s_valid = 1'b1;
    s_data  = 8'h41;
    @(posedge clk);
    #1 s_valid = 1'b0;
    @(negedge clk);
    chk("lat_we", reg_char_we, 4'b0001);
    chk("lat_di", reg_char_di, mk(0, 0, 8'h41));
    chk("lat_ready_low", s_ready, 0);
    chk("lat_busy", busy, 1);
    @(negedge clk);
    chk("lat_ready_back", s_ready, 1);
    chk("lat_we_off", reg_char_we, 0);
    chk("lat_cur_x", cur_x, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      wq.delete();
      send($sformatf("vec%0d", i), tbl[i].d);
      fw = (wq.size() > 0) ? wq[0] : '1;
      lw = (wq.size() > 0) ? wq[$] : '1;
      chk($sformatf("vec%0d_nw", i), wq.size(), tbl[i].nw);
      if (tbl[i].nw > 0) begin
        chk($sformatf("vec%0d_first", i), fw, tbl[i].first);
        chk($sformatf("vec%0d_last", i), lw, tbl[i].last);
      end
      chk($sformatf("vec%0d_x", i), cur_x, tbl[i].ex);
      chk($sformatf("vec%0d_y", i), cur_y, tbl[i].ey);
    end

    // Last-cell put wraps to row 0 and clears it.
    for (int i = 0; i < 27; i++) send("lf_walk", 8'h0A);
    for (int i = 0; i < 31; i++) send("chr_walk", 8'h78);
    chk("wrap_pre_cur", {cur_x, cur_y}, {5'd31, 5'd27});
    wq.delete();
    send("wrap", 8'h5A);
    chk("wrap_nw", wq.size(), 33);
    chk("wrap_put", (wq.size() > 0) ? wq[0] : '1, mk(31, 27, 8'h5A));
    chk("wrap_clr0", (wq.size() > 1) ? wq[1] : '1, mk(0, 0, 8'h20));
    chk("wrap_clr31", (wq.size() > 0) ? wq[$] : '1, mk(31, 0, 8'h20));
    chk("wrap_cur", {cur_x, cur_y}, 10'd0);

    // Reset in the middle of a line clear.
    wait_ready("abort", pw);
    #1;
    s_valid = 1'b1;
    s_data  = 8'h0A;
    @(posedge clk);
    #1 s_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_in_clr", reg_char_we, 4'b0001);
    #1 resetn = 1'b0;
    #1;
    chk("abort_we", reg_char_we, 0);
    chk("abort_di", reg_char_di, 0);
    chk("abort_ready", s_ready, 0);
    chk("abort_cur_y", cur_y, 0);
    @(negedge clk);
    wq.delete();
    #1 resetn = 1'b1;
    check_clear("clr1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
